// File: rtl/alu_issue_seq.sv
// alu_issue_seq: issue sequencer in front of a 32-bit ALU (decode, hold for EXEC_CYCLES, capture result).
// Define ALU_SEQ_FLAGREG_EN to keep a persistent {V,C,N,Z} flag register that feeds ADDC/SUBB carry-in.
module alu_issue_seq #(
    parameter int DATA_W      = 32,
    parameter int EXEC_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [4:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_f,
    input  logic [3:0]        alu_status,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_f,
    output logic [3:0]        out_status,
    output logic              out_wr,
    output logic [3:0]        flags,
    output logic              err_op
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    localparam logic [4:0] SEL_ZERO = 5'b00111;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
    logic [4:0]        sel_q, sel_d;
    logic [3:0]        st_q, st_d;
    logic              cin_q, cin_d, wr_q, wr_d, ov_q, ov_d, err_q, err_d;
    logic [4:0]        dec_sel;
    logic              dec_cin, dec_wr, dec_legal;
    logic              addc_cin, subb_cin;
    logic              capture;

    assign capture = (state_q == EXEC) && (cnt_q == 4'd0);

`ifdef ALU_SEQ_FLAGREG_EN
    logic [3:0] flags_q, flags_d;
    assign addc_cin = flags_q[2];
    assign subb_cin = flags_q[2];
    assign flags    = flags_q;
    assign flags_d  = capture ? alu_status : flags_q;
    always_ff @(posedge clk or posedge reset)
        if (reset) flags_q <= 4'b0000;
        else       flags_q <= flags_d;
`else
    assign addc_cin = 1'b0;
    assign subb_cin = 1'b1;
    assign flags    = 4'b0000;
`endif

    always_comb begin
        dec_legal = 1'b1;
        dec_wr    = 1'b1;
        dec_cin   = 1'b0;
        dec_sel   = SEL_ZERO;
        case (in_op)
            4'd0:    dec_sel = 5'b00100;
            4'd1:    begin dec_sel = 5'b01100; dec_cin = 1'b1; end
            4'd2:    begin dec_sel = 5'b00100; dec_cin = addc_cin; end
            4'd3:    begin dec_sel = 5'b01100; dec_cin = subb_cin; end
            4'd4:    dec_sel = 5'b00001;
            4'd5:    dec_sel = 5'b00010;
            4'd6:    dec_sel = 5'b00000;
            4'd7:    dec_sel = 5'b00011;
            4'd8:    dec_sel = 5'b00101;
            4'd9:    dec_sel = 5'b00110;
            4'd10:   begin dec_sel = 5'b01100; dec_cin = 1'b1; dec_wr = 1'b0; end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        cin_d   = cin_q;
        wr_d    = wr_q;
        f_d     = f_q;
        st_d    = st_q;
        ov_d    = ov_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                if (dec_legal) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sel_d   = dec_sel;
                    cin_d   = dec_cin;
                    wr_d    = dec_wr;
                    cnt_d   = 4'(EXEC_CYCLES - 1);
                    state_d = EXEC;
                end else begin
                    err_d = 1'b1;
                end
            end
            EXEC: if (capture) begin
                f_d     = alu_f;
                st_d    = alu_status;
                ov_d    = 1'b1;
                sel_d   = SEL_ZERO;
                state_d = DONE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            DONE: if (out_ready) begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= SEL_ZERO;
            cin_q   <= 1'b0;
            wr_q    <= 1'b0;
            f_q     <= '0;
            st_q    <= 4'b0000;
            ov_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            cin_q   <= cin_d;
            wr_q    <= wr_d;
            f_q     <= f_d;
            st_q    <= st_d;
            ov_q    <= ov_d;
            err_q   <= err_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_cin    = cin_q;
    assign alu_sel    = sel_q;
    assign out_valid  = ov_q;
    assign out_f      = f_q;
    assign out_status = st_q;
    assign out_wr     = wr_q;
    assign err_op     = err_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: randomized + directed bench for alu_issue_seq with a behavioural ALU and op-level reference.
// Honours ALU_SEQ_FLAGREG_EN the same way the design does.
module tb_alu_issue_seq;
`ifdef ALU_SEQ_FLAGREG_EN
    localparam bit FLAG_EN = 1'b1;
`else
    localparam bit FLAG_EN = 1'b0;
`endif
    localparam int E1 = 1;
    localparam int E2 = 4;

    logic clk = 1'b0, reset = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0, in_valid2 = 1'b0;
    logic [3:0] in_op = 4'd0;
    logic [31:0] in_a = '0, in_b = '0;
    logic in_ready, alu_cin, out_valid, out_wr, err_op;
    logic [31:0] alu_a, alu_b, alu_f, out_f;
    logic [4:0] alu_sel;
    logic [3:0] alu_status, out_status, flags;
    logic in_ready2, alu_cin2, out_valid2, out_wr2, err_op2;
    logic [31:0] alu_a2, alu_b2, alu_f2, out_f2;
    logic [4:0] alu_sel2;
    logic [3:0] alu_status2, out_status2, flags2;
    int tests = 0, fails = 0;
    logic [3:0] flags_m = 4'b0000;

    always #5 clk = ~clk;

    function automatic logic [35:0] alu_model(input logic [31:0] a, b, input logic cin, input logic [4:0] sel);
        logic [31:0] aa, bb, f;
        logic [32:0] s;
        logic v, c;
        aa = sel[4] ? ~a : a;
        bb = sel[3] ? ~b : b;
        v = 1'b0;
        c = 1'b0;
        case (sel[2:0])
            3'b000: f = aa ^ bb;
            3'b001: f = aa & bb;
            3'b010: f = aa | bb;
            3'b011: f = ~(aa | bb);
            3'b100: begin
                s = {1'b0, aa} + {1'b0, bb} + {32'b0, cin};
                f = s[31:0];
                c = s[32];
                v = (aa[31] == bb[31]) && (f[31] != aa[31]);
            end
            3'b101: f = aa << bb[4:0];
            3'b110: f = aa >> bb[4:0];
            default: f = '0;
        endcase
        return {v, c, f[31], f == 32'd0, f};
    endfunction

    // Op-level reference: result and {V,C,N,Z} from the arithmetic meaning of each opcode.
    function automatic logic [35:0] ref_op(input logic [3:0] op, input logic [31:0] a, b, input logic c);
        logic [31:0] f;
        logic [32:0] s, need;
        logic v, cy;
        v = 1'b0;
        cy = 1'b0;
        case (op)
            4'd0, 4'd2: begin
                s = {1'b0, a} + {1'b0, b} + {32'b0, c};
                f = s[31:0];
                cy = s[32];
                v = (a[31] == b[31]) && (f[31] != a[31]);
            end
            4'd1, 4'd3, 4'd10: begin
                need = {1'b0, b} + {32'b0, ~c};
                f = a - b - {31'b0, ~c};
                cy = {1'b0, a} >= need;
                v = (a[31] != b[31]) && (f[31] != a[31]);
            end
            4'd4: f = a & b;
            4'd5: f = a | b;
            4'd6: f = a ^ b;
            4'd7: f = ~(a | b);
            4'd8: f = a << b[4:0];
            4'd9: f = a >> b[4:0];
            default: f = '0;
        endcase
        return {v, cy, f[31], f == 32'd0, f};
    endfunction

    function automatic logic [4:0] exp_sel(input logic [3:0] op);
        case (op)
            4'd0, 4'd2: return 5'b00100;
            4'd1, 4'd3, 4'd10: return 5'b01100;
            4'd4: return 5'b00001;
            4'd5: return 5'b00010;
            4'd6: return 5'b00000;
            4'd7: return 5'b00011;
            4'd8: return 5'b00101;
            4'd9: return 5'b00110;
            default: return 5'b00111;
        endcase
    endfunction

    assign {alu_status, alu_f}   = alu_model(alu_a, alu_b, alu_cin, alu_sel);
    assign {alu_status2, alu_f2} = alu_model(alu_a2, alu_b2, alu_cin2, alu_sel2);

    alu_issue_seq #(.DATA_W(32), .EXEC_CYCLES(E1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_sel(alu_sel),
        .alu_f(alu_f), .alu_status(alu_status), .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_status(out_status), .out_wr(out_wr), .flags(flags), .err_op(err_op)
    );

    alu_issue_seq #(.DATA_W(32), .EXEC_CYCLES(E2)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .alu_a(alu_a2), .alu_b(alu_b2), .alu_cin(alu_cin2), .alu_sel(alu_sel2),
        .alu_f(alu_f2), .alu_status(alu_status2), .out_valid(out_valid2), .out_ready(1'b1),
        .out_f(out_f2), .out_status(out_status2), .out_wr(out_wr2), .flags(flags2), .err_op(err_op2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, b, input int hold);
        logic [35:0] e;
        logic cm;
        @(negedge clk);
        in_valid = 1'b1;
        in_op = op;
        in_a = a;
        in_b = b;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (op > 4'd10) begin
            chk("err_pulse", err_op, 1);
            chk("err_no_valid", out_valid, 0);
            chk("err_ready", in_ready, 1);
            @(posedge clk);
            #1;
            chk("err_one_cycle", err_op, 0);
            chk("err_no_valid2", out_valid, 0);
            chk("err_ready2", in_ready, 1);
            return;
        end
        cm = (op == 4'd2) ? (FLAG_EN ? flags_m[2] : 1'b0) :
             (op == 4'd3) ? (FLAG_EN ? flags_m[2] : 1'b1) :
             (op == 4'd1 || op == 4'd10);
        chk("alu_sel", alu_sel, exp_sel(op));
        chk("alu_cin", alu_cin, cm);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
        for (int i = 0; i < E1; i++) begin
            chk("valid_early", out_valid, 0);
            @(posedge clk);
            #1;
        end
        e = ref_op(op, a, b, cm);
        if (FLAG_EN) flags_m = e[35:32];
        chk("out_valid", out_valid, 1);
        chk("out_f", out_f, e[31:0]);
        chk("out_status", out_status, e[35:32]);
        chk("out_wr", out_wr, op != 4'd10);
        chk("flags", flags, flags_m);
        chk("sel_done", alu_sel, 5'b00111);
        chk("ready_done", in_ready, 0);
        in_valid = 1'b1;
        in_op = 4'($urandom_range(0, 10));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_f", out_f, e[31:0]);
            chk("hold_status", out_status, e[35:32]);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_valid", out_valid, 0);
        chk("drain_no_accept", in_ready, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_sel", alu_sel, 5'b00111);
        chk("rst_f", out_f, 0);
        chk("rst_flags", flags, 0);
        chk("rst_err", err_op, 0);
        @(negedge clk);
        reset = 1'b0;
        do_op(4'd0, 32'h7FFFFFFF, 32'h1, 0);
        do_op(4'd1, 32'd5, 32'd5, 10);
        do_op(4'd10, 32'd3, 32'd7, 0);
        do_op(4'd0, 32'hFFFFFFFF, 32'h1, 0);
        do_op(4'd2, 32'd0, 32'd0, 0);
        do_op(4'hC, 32'd1, 32'd2, 0);
        for (int n = 0; n < 60; n++)
            do_op(4'($urandom_range(0, 15)), $urandom, (n % 4 == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  int'($urandom_range(0, 3)));
        @(negedge clk);
        in_valid2 = 1'b1;
        in_op = 4'd0;
        in_a = 32'h7FFFFFFF;
        in_b = 32'h1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        chk("e4_sel", alu_sel2, 5'b00100);
        @(posedge clk);
        #1;
        chk("e4_busy", out_valid2, 0);
        chk("e4_not_ready", in_ready2, 0);
        reset = 1'b1;
        #1;
        chk("e4_rst_valid", out_valid2, 0);
        chk("e4_rst_flags", flags2, 0);
        chk("e4_rst_sel", alu_sel2, 5'b00111);
        chk("e4_rst_ready", in_ready2, 1);
        chk("e4_rst_a", alu_a2, 0);
        chk("rst_flags_main", flags, 0);
        chk("rst_out_f_main", out_f, 0);
        flags_m = 4'b0000;
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("e4_dropped", out_valid2, 0);
        do_op(4'd2, 32'd0, 32'd0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
